// File: rtl/avalon_pio_pkg.sv
// Shared constants for the avalon_pio_ext parallel I/O port: register word
// addresses and edge-capture sense encodings.
package avalon_pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/avalon_pio_sync_edge.sv
// Per-bit pin synchroniser (SYNC_STAGES deep) with a one-sample delay for edge
// detection. The edge port and delay flop exist only with AVALON_PIO_IRQ_EN.
module avalon_pio_sync_edge
  import avalon_pio_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int EDGE_TYPE   = EDGE_RISE,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] pin_i,
  output logic [DATA_W-1:0] in_sync_o
`ifdef AVALON_PIO_IRQ_EN
  ,
  output logic [DATA_W-1:0] edge_o
`endif
);

  logic [SYNC_STAGES-1:0][DATA_W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
  end

  assign in_sync_o = sync_q[SYNC_STAGES-1];

`ifdef AVALON_PIO_IRQ_EN
  // prev starts at 0, so a pin that is high out of reset reads as a rising edge
  logic [DATA_W-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (!reset_n) prev_q <= '0;
    else          prev_q <= in_sync_o;
  end

  always_comb begin
    case (EDGE_TYPE)
      EDGE_FALL: edge_o = prev_q & ~in_sync_o;
      EDGE_ANY:  edge_o = prev_q ^ in_sync_o;
      default:   edge_o = ~prev_q & in_sync_o;
    endcase
  end
`endif

endmodule

// File: rtl/avalon_pio_ext.sv
// Zero-wait-state Avalon-MM PIO: data/direction/set/clear registers, synchronised
// pin readback; irqmask, edgecapture and irq only when AVALON_PIO_IRQ_EN is defined.
module avalon_pio_ext
  import avalon_pio_pkg::*;
#(
  parameter int                DATA_W      = 16,
  parameter logic [DATA_W-1:0] RESET_OUT   = '0,
  parameter logic [DATA_W-1:0] RESET_DIR   = '1,
  parameter int                EDGE_TYPE   = EDGE_RISE,
  parameter int                SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  output logic [DATA_W-1:0] out_oe,
  output logic              irq
);

  logic              wr;
  logic [DATA_W-1:0] wdata, in_sync, rd;
  logic [DATA_W-1:0] out_q, out_d, dir_q, dir_d;
  logic              unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign wdata        = writedata[DATA_W-1:0];
  assign unused_wdata = ^writedata;

`ifdef AVALON_PIO_IRQ_EN
  logic [DATA_W-1:0] edge_pls, mask_q, mask_d, ecap_q, ecap_d;

  avalon_pio_sync_edge #(.DATA_W(DATA_W), .EDGE_TYPE(EDGE_TYPE), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .reset_n(reset_n), .pin_i(in_port), .in_sync_o(in_sync), .edge_o(edge_pls)
  );

  // new edges are OR'd in after the clear so a coincident edge wins
  always_comb begin
    mask_d = mask_q;
    ecap_d = ecap_q;
    if (wr && address == ADDR_IRQMASK) mask_d = wdata;
    if (wr && address == ADDR_EDGECAP) ecap_d = ecap_q & ~wdata;
    ecap_d = ecap_d | edge_pls;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask_q <= '0;
      ecap_q <= '0;
    end else begin
      mask_q <= mask_d;
      ecap_q <= ecap_d;
    end
  end

  assign irq = |(ecap_q & mask_q);
`else
  avalon_pio_sync_edge #(.DATA_W(DATA_W), .EDGE_TYPE(EDGE_TYPE), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .reset_n(reset_n), .pin_i(in_port), .in_sync_o(in_sync)
  );

  assign irq = 1'b0;
`endif

  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    if (wr) begin
      case (address)
        ADDR_DATA:   out_d = wdata;
        ADDR_DIR:    dir_d = wdata;
        ADDR_OUTSET: out_d = out_q | wdata;
        ADDR_OUTCLR: out_d = out_q & ~wdata;
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_q <= RESET_OUT;
      dir_q <= RESET_DIR;
    end else begin
      out_q <= out_d;
      dir_q <= dir_d;
    end
  end

  assign out_port = out_q;
  assign out_oe   = dir_q;

  always_comb begin
    rd = '0;
    case (address)
      ADDR_DATA:    rd = in_sync;
      ADDR_DIR:     rd = dir_q;
`ifdef AVALON_PIO_IRQ_EN
      ADDR_IRQMASK: rd = mask_q;
      ADDR_EDGECAP: rd = ecap_q;
`endif
      default:      rd = '0;
    endcase
    readdata             = '0;
    readdata[DATA_W-1:0] = rd;
  end

endmodule

// File: tb/tb_avalon_pio_ext.sv
// Directed bench for avalon_pio_ext (DATA_W=16, RESET_OUT=16'h00A5, rising edges,
// 2-stage sync). IRQ checks are compiled in when AVALON_PIO_IRQ_EN is defined.
module tb_avalon_pio_ext;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] in_port;
  logic [15:0] out_port;
  logic [15:0] out_oe;
  logic        irq;

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  avalon_pio_ext #(
    .DATA_W(16), .RESET_OUT(16'h00A5), .RESET_DIR(16'hFFFF), .EDGE_TYPE(0), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .out_oe(out_oe), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // called at a negedge; returns at the negedge after the write edge
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    write_n    = 1'b1;
    chipselect = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  initial begin
    reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'h0; in_port = 16'h0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    chk("rst_out_port", {16'h0, out_port}, 32'h00A5);
    chk("rst_out_oe",   {16'h0, out_oe},   32'hFFFF);
    chk("rst_irq",      {31'h0, irq},      32'h0);
    repeat (2) @(negedge clk);
    rd("rst_rd_data", 3'd0, 32'h0);

    wr(3'd4, 32'h0000_00F0);
    chk("outset", {16'h0, out_port}, 32'h00F5);
    wr(3'd5, 32'h0000_0081);
    chk("outclr", {16'h0, out_port}, 32'h0074);
    rd("rd_outset", 3'd4, 32'h0);
    rd("rd_outclr", 3'd5, 32'h0);

    wr(3'd0, 32'hFFFF_1234);
    chk("data_wr", {16'h0, out_port}, 32'h1234);
    wr(3'd1, 32'h0);
    chk("dir_zero_oe",  {16'h0, out_oe},   32'h0);
    chk("dir_zero_out", {16'h0, out_port}, 32'h1234);
    rd("rd_dir0", 3'd1, 32'h0);
    wr(3'd1, 32'hABCD_00FF);
    rd("rd_dir_ff", 3'd1, 32'h0000_00FF);

    wr(3'd6, 32'hFFFF_FFFF);
    rd("rsv6_rd", 3'd6, 32'h0);
    rd("rsv7_rd", 3'd7, 32'h0);
    chk("rsv_out", {16'h0, out_port}, 32'h1234);

    // non-chipselected write strobe does nothing
    address = 3'd0; writedata = 32'h0; write_n = 1'b0; chipselect = 1'b0;
    @(negedge clk);
    write_n = 1'b1;
    chk("no_cs", {16'h0, out_port}, 32'h1234);

    in_port = 16'h5A5A;
    @(negedge clk);
    rd("sync_lat1", 3'd0, 32'h0);
    @(negedge clk);
    rd("sync_lat2", 3'd0, 32'h5A5A);
    in_port = 16'h0;
    repeat (3) @(negedge clk);
    rd("sync_back0", 3'd0, 32'h0);

`ifdef AVALON_PIO_IRQ_EN
    wr(3'd3, 32'hFFFF);
    rd("ecap_cleared", 3'd3, 32'h0);
    wr(3'd2, 32'h0001);
    rd("rd_mask", 3'd2, 32'h0001);
    chk("irq_idle", {31'h0, irq}, 32'h0);

    in_port = 16'h0001;
    @(negedge clk);
    chk("irq_lat1", {31'h0, irq}, 32'h0);
    @(negedge clk);
    chk("irq_lat2", {31'h0, irq}, 32'h0);
    @(negedge clk);
    chk("irq_lat3", {31'h0, irq}, 32'h1);
    rd("ecap_set", 3'd3, 32'h0001);

    wr(3'd3, 32'h0000);
    chk("ecap_wr0_keeps", {31'h0, irq}, 32'h1);
    wr(3'd3, 32'h0001);
    chk("ecap_clr_irq", {31'h0, irq}, 32'h0);

    // falling edge must not capture with rising sense
    in_port = 16'h0000;
    repeat (4) @(negedge clk);
    rd("fall_ignored", 3'd3, 32'h0);

    // clear lands on the same edge that captures: set wins
    in_port = 16'h0001;
    @(negedge clk);
    @(negedge clk);
    wr(3'd3, 32'h0001);
    rd("set_wins", 3'd3, 32'h0001);
    chk("set_wins_irq", {31'h0, irq}, 32'h1);

    wr(3'd2, 32'h0000);
    chk("mask_off_irq", {31'h0, irq}, 32'h0);
    wr(3'd3, 32'h0001);
    rd("ecap_final", 3'd3, 32'h0);
`else
    wr(3'd2, 32'hFFFF);
    wr(3'd3, 32'hFFFF);
    for (int i = 0; i < 4; i++) begin
      in_port = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
      repeat (3) @(negedge clk);
      chk("noirq_irq", {31'h0, irq}, 32'h0);
    end
    rd("noirq_rd2", 3'd2, 32'h0);
    rd("noirq_rd3", 3'd3, 32'h0);
`endif

    // reset in the same cycle as a write discards the write
    address = 3'd0; writedata = 32'h0000_BEEF; chipselect = 1'b1; write_n = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; reset_n = 1'b1;
    chk("rst_mid_out", {16'h0, out_port}, 32'h00A5);
    chk("rst_mid_oe",  {16'h0, out_oe},   32'hFFFF);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
